// File: rtl/hyperbus_w_packer.sv
// hyperbus_w_packer: merges narrow AXI W beats into full-width words for the
// HyperBus PHY-side transaction buffer. It places data and strobes by lane and
// raises a single last. It also flags bursts whose AXI last disagrees with the
// announced beat count.
module hyperbus_w_packer #(
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned LenWidth     = 8,
    parameter int unsigned OffWidth     = $clog2(AxiDataWidth / 8)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [OffWidth-1:0]       cmd_addr_i,
    input  logic [2:0]                cmd_size_i,
    input  logic [LenWidth-1:0]       cmd_len_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [AxiDataWidth-1:0]   in_data_i,
    input  logic [AxiDataWidth/8-1:0] in_strb_i,
    input  logic                      in_last_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [AxiDataWidth-1:0]   out_data_o,
    output logic [AxiDataWidth/8-1:0] out_strb_o,
    output logic                      out_last_o,
    output logic                      err_o
);

    localparam int unsigned NB = AxiDataWidth / 8;
    localparam logic [2:0] MaxSize = 3'($clog2(NB));

    typedef enum logic {
        IDLE,
        PACK
    } state_t;

    state_t                 state_q;
    logic [OffWidth-1:0]    offset_q;
    logic [2:0]             size_q;
    logic [LenWidth-1:0]    cnt_q;
    logic [LenWidth-1:0]    len_q;
    logic [AxiDataWidth-1:0] acc_data_q;
    logic [NB-1:0]          acc_strb_q;
    logic                   out_valid_q;
    logic [AxiDataWidth-1:0] out_data_q;
    logic [NB-1:0]          out_strb_q;
    logic                   out_last_q;
    logic                   err_q;

    logic [2:0]             cmd_size_clamped;
    logic [OffWidth:0]      beat_bytes;
    logic [OffWidth-1:0]    align_mask;
    logic [OffWidth-1:0]    aligned_offset;
    logic [OffWidth:0]      window_end;
    logic [OffWidth-1:0]    next_offset;
    logic                   final_beat;
    logic                   word_done;
    logic                   beat_fire;
    logic [OffWidth:0]      lane_idx;
    logic [AxiDataWidth-1:0] merged_data;
    logic [NB-1:0]          merged_strb;

    // Command-side and beat-side handshakes depend only on state and the output slot.
    assign cmd_ready_o = (state_q == IDLE);
    assign in_ready_o  = (state_q == PACK) && (!out_valid_q || out_ready_i);
    assign beat_fire   = in_valid_i && in_ready_o;

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_strb_o  = out_strb_q;
    assign out_last_o  = out_last_q;
    assign err_o       = err_q;

    // Sizes wider than the bus behave as full-width beats.
    assign cmd_size_clamped = (cmd_size_i > MaxSize) ? MaxSize : cmd_size_i;

    // Lane window of the current beat: from the current offset up to the end of the
    // size-aligned slot; subsequent offsets are always aligned, so one rule covers all beats.
    always_comb begin
        beat_bytes     = (OffWidth + 1)'(1) << size_q;
        align_mask     = ~(beat_bytes[OffWidth-1:0] - OffWidth'(1));
        aligned_offset = offset_q & align_mask;
        window_end     = {1'b0, aligned_offset} + beat_bytes;
        next_offset    = window_end[OffWidth-1:0];
        final_beat     = (cnt_q == len_q);
        word_done      = (next_offset == '0) || final_beat;
    end

    // Overlay the in-window lanes of the incoming beat onto the accumulator.
    always_comb begin
        merged_data = acc_data_q;
        merged_strb = acc_strb_q;
        lane_idx    = '0;
        for (int i = 0; i < NB; i++) begin
            lane_idx = (OffWidth + 1)'(i);
            if ((lane_idx >= {1'b0, offset_q}) && (lane_idx < window_end)) begin
                merged_data[i*8 +: 8] = in_data_i[i*8 +: 8];
                merged_strb[i]        = in_strb_i[i];
            end
        end
    end

    // Burst FSM with accumulator, output register and last-mismatch pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            offset_q    <= '0;
            size_q      <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            acc_data_q  <= '0;
            acc_strb_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (out_valid_q && out_ready_i) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        state_q    <= PACK;
                        offset_q   <= cmd_addr_i;
                        size_q     <= cmd_size_clamped;
                        cnt_q      <= '0;
                        len_q      <= cmd_len_i;
                        acc_data_q <= '0;
                        acc_strb_q <= '0;
                    end
                end
                PACK: begin
                    if (beat_fire) begin
                        cnt_q    <= cnt_q + LenWidth'(1);
                        offset_q <= next_offset;
                        err_q    <= (in_last_i != final_beat);
                        if (word_done) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= merged_data;
                            out_strb_q  <= merged_strb;
                            out_last_q  <= final_beat;
                            acc_data_q  <= '0;
                            acc_strb_q  <= '0;
                        end else begin
                            acc_data_q <= merged_data;
                            acc_strb_q <= merged_strb;
                        end
                        if (final_beat) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hyperbus_w_packer.sv
// Directed testbench for hyperbus_w_packer with a 64-bit bus (NB=8).
module tb_hyperbus_w_packer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_addr;
    logic [2:0]  cmd_size;
    logic [7:0]  cmd_len;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [7:0]  in_strb;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [7:0]  out_strb;
    logic        out_last;
    logic        err;

    int assertCount = 0;
    int failCount   = 0;

    hyperbus_w_packer #(
        .AxiDataWidth(64),
        .LenWidth(8)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_addr_i(cmd_addr),
        .cmd_size_i(cmd_size),
        .cmd_len_i(cmd_len),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .in_data_i(in_data),
        .in_strb_i(in_strb),
        .in_last_i(in_last),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o(out_data),
        .out_strb_o(out_strb),
        .out_last_o(out_last),
        .err_o(err)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendCommand(input logic [2:0] addr, input logic [2:0] size,
                               input logic [7:0] len);
        @(negedge clk);
        checkOutput("cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_size  = size;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Present one beat at the negedge, wait (bounded) for in_ready, complete on the posedge.
    task automatic applyStimulus(input logic [63:0] data, input logic [7:0] strb,
                                 input logic last);
        int waitCycles = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = data;
        in_strb  = strb;
        in_last  = last;
        while (!in_ready && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("in_ready_at_beat", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [63:0] laneByte(input int lane, input logic [7:0] value);
        logic [63:0] d;
        d = 64'hEEEE_EEEE_EEEE_EEEE;
        d[lane*8 +: 8] = value;
        return d;
    endfunction

    logic [63:0] fullWords [4];
    logic [7:0]  fullStrbs [4];
    logic        lastPattern [4];

    initial begin
        fullWords[0] = 64'h0102030405060708;
        fullWords[1] = 64'hA0B0C0D0E0F01020;
        fullWords[2] = 64'h1122334455667788;
        fullWords[3] = 64'hFEDCBA9876543210;
        fullStrbs[0] = 8'hFF;
        fullStrbs[1] = 8'hA5;
        fullStrbs[2] = 8'h0F;
        fullStrbs[3] = 8'hF0;
        lastPattern[0] = 1'b0;
        lastPattern[1] = 1'b1;
        lastPattern[2] = 1'b0;
        lastPattern[3] = 1'b1;

        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_size  = '0;
        cmd_len   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_strb   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_strb", out_strb, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Byte beats, addr 0, len 7: one packed word after the eighth beat
        $display("[TB] byte packing");
        out_ready = 1'b1;
        sendCommand(3'd0, 3'd0, 8'd7);
        checkOutput("t1_cmd_ready_busy", cmd_ready, 0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(laneByte(k, 8'(8'h11 * (k + 1))), 8'hFF, (k == 7));
            if (k < 7) checkOutput("t1_no_early_valid", out_valid, 0);
        end
        checkOutput("t1_valid", out_valid, 1);
        checkOutput("t1_data", out_data, 64'h8877665544332211);
        checkOutput("t1_strb", out_strb, 8'hFF);
        checkOutput("t1_last", out_last, 1);
        tick();
        checkOutput("t1_drained", out_valid, 0);

        // Unaligned halfword beats, addr 2, len 3: two words
        $display("[TB] unaligned halfword packing");
        sendCommand(3'd2, 3'd1, 8'd3);
        for (int k = 0; k < 4; k++) begin
            applyStimulus({8{8'(8'h11 * (k + 1))}}, 8'hFF, (k == 3));
            if (k < 2) checkOutput("t2_no_early_valid", out_valid, 0);
            if (k == 2) begin
                checkOutput("t2_w0_valid", out_valid, 1);
                checkOutput("t2_w0_data", out_data, 64'h3333222211110000);
                checkOutput("t2_w0_strb", out_strb, 8'hFC);
                checkOutput("t2_w0_last", out_last, 0);
            end
        end
        checkOutput("t2_w1_valid", out_valid, 1);
        checkOutput("t2_w1_data", out_data, 64'h0000000000004444);
        checkOutput("t2_w1_strb", out_strb, 8'h03);
        checkOutput("t2_w1_last", out_last, 1);
        tick();
        checkOutput("t2_drained", out_valid, 0);

        // Full-width pass-through, len 3: one word per cycle
        $display("[TB] full-width pass-through");
        sendCommand(3'd0, 3'd3, 8'd3);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(fullWords[k], fullStrbs[k], (k == 3));
            checkOutput("t3_valid", out_valid, 1);
            checkOutput("t3_data", out_data, fullWords[k]);
            checkOutput("t3_strb", out_strb, {56'h0, fullStrbs[k]});
            checkOutput("t3_last", out_last, (k == 3));
        end
        tick();
        checkOutput("t3_drained", out_valid, 0);

        // Word size with output backpressure and a back-to-back command
        $display("[TB] backpressure");
        out_ready = 1'b0;
        sendCommand(3'd0, 3'd2, 8'd1);
        applyStimulus(64'hDEADBEEF44332211, 8'hFF, 1'b0);
        checkOutput("t4_no_early_valid", out_valid, 0);
        applyStimulus(64'h88776655CAFEF00D, 8'hFF, 1'b1);
        checkOutput("t4_valid", out_valid, 1);
        checkOutput("t4_data", out_data, 64'h8877665544332211);
        checkOutput("t4_strb", out_strb, 8'hFF);
        checkOutput("t4_last", out_last, 1);
        tick();
        tick();
        checkOutput("t4_hold_valid", out_valid, 1);
        checkOutput("t4_hold_data", out_data, 64'h8877665544332211);
        sendCommand(3'd0, 3'd3, 8'd0);
        for (int k = 0; k < 3; k++) begin
            checkOutput("t4_in_ready_blocked", in_ready, 0);
            checkOutput("t4_hold_valid2", out_valid, 1);
            checkOutput("t4_hold_strb", out_strb, 8'hFF);
            tick();
        end
        @(negedge clk);
        out_ready = 1'b1;
        tick();
        checkOutput("t4_single_handshake", out_valid, 0);
        applyStimulus(64'h0123456789ABCDEF, 8'hFF, 1'b1);
        checkOutput("t4_next_valid", out_valid, 1);
        checkOutput("t4_next_data", out_data, 64'h0123456789ABCDEF);
        checkOutput("t4_next_last", out_last, 1);
        checkOutput("t4_idle", cmd_ready, 1);
        tick();
        checkOutput("t4_drained", out_valid, 0);

        // Early last on the second beat raises err one cycle later
        $display("[TB] last mismatch");
        sendCommand(3'd0, 3'd0, 8'd3);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(laneByte(k, 8'(8'hA1 + k)), 8'hFF, lastPattern[k]);
            checkOutput("t5_err", err, (k == 1));
            if (k < 3) checkOutput("t5_no_early_valid", out_valid, 0);
        end
        checkOutput("t5_valid", out_valid, 1);
        checkOutput("t5_data", out_data, 64'h00000000A4A3A2A1);
        checkOutput("t5_strb", out_strb, 8'h0F);
        checkOutput("t5_last", out_last, 1);
        tick();
        checkOutput("t5_drained", out_valid, 0);

        // Asynchronous reset mid-burst, then a clean burst
        $display("[TB] reset mid-burst");
        sendCommand(3'd0, 3'd0, 8'd7);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(laneByte(k, 8'h55), 8'hFF, 1'b0);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_cmd_ready", cmd_ready, 1);
        checkOutput("t6_in_ready", in_ready, 0);
        checkOutput("t6_out_valid", out_valid, 0);
        checkOutput("t6_out_data", out_data, 0);
        checkOutput("t6_out_strb", out_strb, 0);
        checkOutput("t6_out_last", out_last, 0);
        checkOutput("t6_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sendCommand(3'd0, 3'd0, 8'd1);
        applyStimulus(laneByte(0, 8'hAA), 8'hFF, 1'b0);
        applyStimulus(laneByte(1, 8'hBB), 8'hFF, 1'b1);
        checkOutput("t6_valid", out_valid, 1);
        checkOutput("t6_data", out_data, 64'h000000000000BBAA);
        checkOutput("t6_strb", out_strb, 8'h03);
        checkOutput("t6_last", out_last, 1);
        checkOutput("t6_no_err", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/hyperbus_w_packer.md
# hyperbus_w_packer

Parametrised AXI write-data packer in the HyperBus controller write path, between the AXI W channel and the PHY-side transaction buffer. It merges narrow AXI beats (size below full bus width, aligned or unaligned start) into full-width words with correct byte strobes and a single `last`. It supports any power-of-two data width, any beat size, burst lengths up to 2^LenWidth beats and zero-bubble full-width pass-through. It also checks the incoming `last` flag against the beat count of the announced burst.

## Interface
- `AxiDataWidth`, 64: data width in bits, power of two, ≥16; `NB = AxiDataWidth/8`.
- `LenWidth`, 8: width of the AXI burst length field (beats − 1).
- `OffWidth`, `$clog2(NB)`: byte-offset width (derived, do not override).
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `cmd_valid_i`  in  1  burst descriptor valid.
- `cmd_ready_o`  out  1  descriptor accepted (high in IDLE).
- `cmd_addr_i`  in  OffWidth  start byte offset within the bus word.
- `cmd_size_i`  in  3  AXI size (log2 bytes per beat).
- `cmd_len_i`  in  LenWidth  AXI len (beats − 1).
- `in_valid_i`, `in_ready_o`  in/out  1  W beat handshake.
- `in_data_i`  in  AxiDataWidth  beat data, AXI lane placement.
- `in_strb_i`  in  NB  beat strobes.
- `in_last_i`  in  1  AXI last.
- `out_valid_o`, `out_ready_i`  out/in  1  packed word handshake.
- `out_data_o`  out  AxiDataWidth  packed data.
- `out_strb_o`  out  NB  packed strobes.
- `out_last_o`  out  1  final word of the burst.
- `err_o`  out  1  one-cycle pulse on `last` mismatch.

## Operation
- States: IDLE, PACK.
  - IDLE → PACK on `cmd_valid_i && cmd_ready_o`. Latch offset = `cmd_addr_i`, size = min(`cmd_size_i`, log2 NB), beat counter = 0, len = `cmd_len_i`. Clear the accumulator.
  - PACK → IDLE when the beat with counter == len is accepted.
- Beat lanes:
  - First beat covers bytes offset .. (offset aligned down to 2^size) + 2^size − 1.
  - Later beats cover 2^size bytes starting at the aligned offset.
  - Only lanes inside that window are copied from `in_data_i`. Strobe bits in the window are taken as `in_strb_i`; all other strobe bits are left untouched.
  - Accumulator strobes start at 0 for each new word.
- Offset update per accepted beat: offset = aligned(offset) + 2^size, mod NB (OffWidth wrap).
- Word completion: the word moves to the output register when the offset wraps to 0 or the final beat is accepted. `out_last_o` = final beat.
- Full-width size: every beat is one word. Data and strobes pass through unchanged.
- Handshake:
  - `in_ready_o` = PACK && (!`out_valid_o` || `out_ready_i`).
  - The output register holds data, strobes and last stable while `out_valid_o && !out_ready_i`.
- Bursts are back to back: a new command may be accepted in IDLE while the previous final word is still waiting in the output register.
- Error: `err_o` pulses the cycle after an accepted beat where `in_last_i` ≠ (counter == len). The counter is authoritative and no beats are dropped.
- Sizes above log2 NB are clamped to the full width.

## Timing
- Reset values: `out_valid_o`=0, `out_data_o`=0, `out_strb_o`=0, `out_last_o`=0, `err_o`=0, `in_ready_o`=0, `cmd_ready_o`=1, state IDLE.
- `cmd_ready_o` is combinational from state.
- The first `in_ready_o` comes one cycle after command acceptance.
- Latency: a beat that completes a word produces `out_valid_o` in the next cycle, registered.
- Throughput:
  - Full width: 1 word per cycle with `out_ready_i` held high.
  - Size s: 1 word per NB/2^s beats, no bubbles.
- Simultaneous output drain and completing beat in the same cycle: the output register loads the new word and `out_valid_o` stays high.
- Simultaneous drain and non-completing beat: `out_valid_o` drops, and the accumulator continues with the partial word.
- Counter wraps at LenWidth bits; len = 2^LenWidth − 1 is legal.
- Reset mid-burst: everything returns to reset values, the partial word is discarded and there is no `err_o`.

## Test plan
- NB=8. Cmd addr=0, size=0, len=7; bytes 0x11..0x88 on lanes 0..7, all strb=1, `out_ready_i`=1 → one word 0x8877665544332211, strb 0xFF, last=1, valid one cycle after beat 8.
- NB=8. Cmd addr=2, size=1, len=3 → word 0 strb 0xFC after beat 3; word 1 strb 0x03, last=1.
- NB=8. Size=3, len=3, `out_ready_i`=1 → 4 words on 4 consecutive cycles, data unchanged, last on word 4, `in_ready_o` never drops.
- NB=8. Size=2, len=1, `out_ready_i`=0 for 5 cycles → output holds, `in_ready_o`=0. Release → single handshake, then IDLE.
- NB=8. Size=0, len=3, `in_last_i`=1 on beat 2 → `err_o` pulse one cycle later. The output word carries strb 0x0F and last=1 after beat 4.
- Assert `rst_ni` after 3 of 8 beats → all outputs at reset values asynchronously. Next burst packs from a clean accumulator.
